// File: rtl/id_ex_stage_if.sv
// Decode-to-execute stage bus: decode-side handshake, execute-side handshake,
// flush request and occupancy.
interface id_ex_stage_if #(
    parameter int DATA_W = 96,
    parameter int PC_W   = 32,
    parameter int INS_W  = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [INS_W-1:0]  in_ins;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [INS_W-1:0]  out_ins;
    logic [PC_W-1:0]   out_pc;
    logic [PC_W-1:0]   out_pc_link;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occ;

    // master is the pipeline around the stage, slave is the stage itself
    modport master (
        output flush, in_valid, in_ins, in_pc, in_data, out_ready,
        input  in_ready, out_valid, out_ins, out_pc, out_pc_link, out_data, occ
    );

    modport slave (
        input  flush, in_valid, in_ins, in_pc, in_data, out_ready,
        output in_ready, out_valid, out_ins, out_pc, out_pc_link, out_data, occ
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake and synchronous flush.
// Define ID_EX_SKID_EN to add a second (skid) entry and a registered in_ready.
module id_ex_stage #(
    parameter int DATA_W = 96,
    parameter int PC_W   = 32,
    parameter int INS_W  = 32,
    parameter int PC_INC = 4
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);
    logic              main_valid;
    logic [INS_W-1:0]  main_ins;
    logic [PC_W-1:0]   main_pc;
    logic [PC_W-1:0]   main_link;
    logic [DATA_W-1:0] main_data;

    logic              in_fire;
    logic              main_drain;
    logic [PC_W-1:0]   in_link;

    assign in_fire    = bus.in_valid && bus.in_ready;
    assign main_drain = main_valid && bus.out_ready;
    // Link PC is formed at capture so the execute side sees a plain register.
    assign in_link    = bus.in_pc + PC_W'(PC_INC);

    assign bus.out_valid   = main_valid;
    assign bus.out_ins     = main_ins;
    assign bus.out_pc      = main_pc;
    assign bus.out_pc_link = main_link;
    assign bus.out_data    = main_data;

`ifdef ID_EX_SKID_EN
    logic              skid_valid;
    logic [INS_W-1:0]  skid_ins;
    logic [PC_W-1:0]   skid_pc;
    logic [PC_W-1:0]   skid_link;
    logic [DATA_W-1:0] skid_data;

    // Ready depends only on stored state, so out_ready never reaches decode.
    assign bus.in_ready = !rst && !skid_valid;
    assign bus.occ      = {skid_valid, main_valid & ~skid_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_ins   <= '0;
            main_pc    <= '0;
            main_link  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ins   <= '0;
            skid_pc    <= '0;
            skid_link  <= '0;
            skid_data  <= '0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // in_ready is low here, so only a drain can happen
            if (main_drain) begin
                main_ins   <= skid_ins;
                main_pc    <= skid_pc;
                main_link  <= skid_link;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (in_fire) begin
            if (!main_valid || main_drain) begin
                main_valid <= 1'b1;
                main_ins   <= bus.in_ins;
                main_pc    <= bus.in_pc;
                main_link  <= in_link;
                main_data  <= bus.in_data;
            end else begin
                skid_valid <= 1'b1;
                skid_ins   <= bus.in_ins;
                skid_pc    <= bus.in_pc;
                skid_link  <= in_link;
                skid_data  <= bus.in_data;
            end
        end else if (main_drain) begin
            main_valid <= 1'b0;
        end
    end
`else
    assign bus.in_ready = !rst && (!main_valid || bus.out_ready);
    assign bus.occ      = {1'b0, main_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_ins   <= '0;
            main_pc    <= '0;
            main_link  <= '0;
            main_data  <= '0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
        end else if (in_fire) begin
            main_valid <= 1'b1;
            main_ins   <= bus.in_ins;
            main_pc    <= bus.in_pc;
            main_link  <= in_link;
            main_data  <= bus.in_data;
        end else if (main_drain) begin
            main_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a capacity-limited FIFO model predicts
// in_ready/out_valid/occ and the order and contents of emitted entries.
module tb_id_ex_stage;
    localparam int DATA_W = 96;
    localparam int PC_W   = 32;
    localparam int INS_W  = 32;
`ifdef ID_EX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic [INS_W-1:0]  ins;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   link;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic rst_seen;
    bit   pop_pending;
    int   compared;
    int   mismatched;
    exp_t exp_q[$];

    id_ex_stage_if #(.DATA_W(DATA_W), .PC_W(PC_W), .INS_W(INS_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .INS_W(INS_W), .PC_INC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // The stage is a FIFO of CAP entries; without the skid entry a full
    // stage still accepts when its sole entry leaves in the same cycle.
    function automatic bit modelReady();
        if (rst) return 1'b0;
        if (CAP == 2) return exp_q.size() < 2;
        return (exp_q.size() == 0) || bus.out_ready;
    endfunction

    task automatic applyStimulus(input bit v, input logic [PC_W-1:0] pc, input bit ordy,
                                 input bit fl, input bit r);
        exp_t e;
        bit   acc;
        e.ins  = $urandom;
        e.pc   = pc;
        e.link = pc + 32'd4;
        e.data = {$urandom, $urandom, $urandom};
        bus.in_valid  = v;
        bus.in_ins    = e.ins;
        bus.in_pc     = pc;
        bus.in_data   = e.data;
        bus.out_ready = ordy;
        bus.flush     = fl;
        rst           = r;
        @(negedge clk);
        acc = v && modelReady() && !r && !fl;
        @(posedge clk);
        if (acc) exp_q.push_back(e);
        #1;
    endtask

    always @(posedge clk) rst_seen <= rst;

    // Monitor: compare handshake state every cycle and contents on each transfer out
    always @(negedge clk) begin
        checkOutput("in_ready", 128'(bus.in_ready), 128'(modelReady()));
        checkOutput("out_valid", 128'(bus.out_valid), 128'(exp_q.size() != 0));
        checkOutput("occ", 128'(bus.occ), 128'(exp_q.size()));
        if (rst_seen) begin
            checkOutput("rst_out_ins", 128'(bus.out_ins), 128'(0));
            checkOutput("rst_out_pc", 128'(bus.out_pc), 128'(0));
            checkOutput("rst_out_pc_link", 128'(bus.out_pc_link), 128'(0));
            checkOutput("rst_out_data", 128'(bus.out_data), 128'(0));
        end
        if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
            checkOutput("out_ins", 128'(bus.out_ins), 128'(exp_q[0].ins));
            checkOutput("out_pc", 128'(bus.out_pc), 128'(exp_q[0].pc));
            checkOutput("out_pc_link", 128'(bus.out_pc_link), 128'(exp_q[0].link));
            checkOutput("out_data", 128'(bus.out_data), 128'(exp_q[0].data));
        end
        pop_pending = (exp_q.size() > 0) && bus.out_ready && !rst && !bus.flush;
    end

    always @(posedge clk) begin
        if (rst || bus.flush) exp_q.delete();
        else if (pop_pending) void'(exp_q.pop_front());
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        // reset held three cycles with in_valid asserted
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // streaming with execute always ready
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // back-pressure: A then B while execute stalls, then drain
        applyStimulus(1'b1, 32'hA00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // flush from a full stage with a simultaneous input
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // link PC wraps at the top of the address space
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // reset and flush together while holding an entry
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h504, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                          $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 1);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
